wb_timer_irq: RTL and testbench
===============================

WB_TIMER_IRQ -- requirements
Module: wb_timer_irq

Interface
REQ-001 The block SHALL expose these ports: i_Clk, input, 1, system clock; all state on rising edge.
REQ-002 The block SHALL expose i_Rstn, input, 1; reset is asynchronous and active-low.
REQ-003 The block SHALL expose i_wb_cyc, input, 1, Wishbone cycle from the peripheral-port arbiter.
REQ-004 The block SHALL expose i_wb_stb, input, 1, Wishbone strobe.
REQ-005 The block SHALL expose i_wb_we, input, 1, write enable.
REQ-006 The block SHALL expose i_wb_addr, input, 32, byte address; bits [4:2] decoded, others ignored.
REQ-007 The block SHALL expose i_wb_data, input, 32, write data.
REQ-008 The block SHALL expose i_wb_sel, input, 4, byte lane enables.
REQ-009 The block SHALL expose o_wb_stall, output, 1, tied 0.
REQ-010 The block SHALL expose o_wb_ack, output, 1, transfer acknowledge.
REQ-011 The block SHALL expose o_wb_data, output, 32, read data.
REQ-012 The block SHALL expose o_irq, output, 1, level interrupt routed to a CPU irq line.

Function
REQ-013 Register map by i_wb_addr[4:2]: 0 CTRL, bit0 EN, bit1 AUTO, bit2 IE; 1 PRESCALE, 16 bits; 2 COMPARE, 32 bits; 3 COUNT, 32 bits, R/W; 4 STATUS, bit0 PEND, write-1-to-clear; 5-7 read 0, writes ignored.
REQ-014 Unused register bits SHALL read 0.
REQ-015 Each cycle with i_wb_cyc & i_wb_stb SHALL produce o_wb_ack=1 exactly one cycle later, for one cycle per request.
REQ-016 Back-to-back requests SHALL be acked on consecutive cycles.
REQ-017 o_wb_ack SHALL be 0 whenever i_wb_cyc=0 in the previous cycle.
REQ-018 Read data SHALL be registered and valid on o_wb_data in the ack cycle.
REQ-019 o_wb_data SHALL be 0 in cycles without ack.
REQ-020 Writes SHALL update only the byte lanes with i_wb_sel[n]=1.
REQ-021 A write with i_wb_sel=0 SHALL be acked and SHALL have no effect.
REQ-022 Prescaler: internal 16-bit PCNT SHALL increment each cycle while EN=1; when PCNT==PRESCALE it SHALL assert one-cycle TICK and return to 0.
REQ-023 PRESCALE=0 SHALL produce TICK every cycle.
REQ-024 On TICK with COUNT!=COMPARE, COUNT SHALL increment by 1, wrapping 0xFFFFFFFF to 0 with no flag.
REQ-025 On TICK with COUNT==COMPARE, the block SHALL set PEND=1.
REQ-026 On a match with AUTO=1, COUNT SHALL go to 0 and EN SHALL stay 1.
REQ-027 On a match with AUTO=0 (one-shot), COUNT SHALL hold and EN SHALL clear to 0.
REQ-028 Writing CTRL with EN=0 SHALL clear PCNT to 0 and freeze COUNT.
REQ-029 Re-enabling SHALL start from PCNT=0.
REQ-030 A bus write to COUNT in the same cycle as a TICK SHALL take priority over the increment or reload.
REQ-031 A W1C write to PEND in the same cycle as a match SHALL leave PEND=1 (set wins).
REQ-032 A write to COMPARE or PRESCALE SHALL take effect from the next cycle's comparison.
REQ-033 o_irq SHALL equal PEND & IE, driven from flops, with no combinational path from the bus inputs.
REQ-034 o_irq SHALL remain high until PEND is cleared or IE is cleared.

Reset
REQ-035 Asserting i_Rstn=0 SHALL immediately, without waiting for a clock, force CTRL=0, PRESCALE=0, COMPARE=0xFFFFFFFF, COUNT=0, PCNT=0, PEND=0, o_wb_ack=0, o_wb_data=0, o_irq=0.
REQ-036 Reset asserted mid-transaction SHALL drop the pending ack.
REQ-037 After reset release, the first request SHALL be acked normally one cycle later.

Verification
REQ-038 Bus: write PRESCALE=0x1234 with sel=4'b0001, then read it -> ack exactly 1 cycle after each stb; read returns 0x00000034.
REQ-039 Auto-reload: PRESCALE=3, COMPARE=2, CTRL=0x7 -> PEND and o_irq rise 12 cycles after EN; COUNT sequence 0,1,2,0 on TICKs.
REQ-040 One-shot: AUTO=0, PRESCALE=0, COMPARE=5 -> PEND set, EN reads 0, COUNT holds 5, no further TICKs.
REQ-041 Collision: W1C to STATUS in the match cycle -> PEND stays 1; a later W1C clears PEND and o_irq drops one cycle later.
REQ-042 Wrap and priority: COUNT written 0xFFFFFFFF, COMPARE=0x10, PRESCALE=0 -> next COUNT is 0; a COUNT write of 0x55 coincident with a TICK -> reads 0x55.
REQ-043 Async reset: assert i_Rstn=0 between clock edges with o_irq=1 and an ack pending -> o_irq, o_wb_ack, CTRL and COUNT are 0 before the next edge.

Source files
------------

// File: rtl/wb_timer_irq.sv
// Wishbone-attached 32-bit timer with a 16-bit prescaler, compare match,
// auto-reload / one-shot modes and a level interrupt driven from flops.
module wb_timer_irq (
    input  logic        i_Clk,
    input  logic        i_Rstn,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [3:0]  i_wb_sel,
    output logic        o_wb_stall,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_data,
    output logic        o_irq
);

    localparam logic [2:0] A_CTRL     = 3'd0;
    localparam logic [2:0] A_PRESCALE = 3'd1;
    localparam logic [2:0] A_COMPARE  = 3'd2;
    localparam logic [2:0] A_COUNT    = 3'd3;
    localparam logic [2:0] A_STATUS   = 3'd4;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic [2:0]  ctrl_q, ctrl_d;          // {IE, AUTO, EN}
    logic [15:0] prescale_q, prescale_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] count_q, count_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic        pend_q, pend_d;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic        irq_q, irq_d;

    logic        req_s, wr_s, rd_s, w1c_s, tick_s, match_s;
    logic [2:0]  addr_s;
    logic [31:0] old_s, merged_s, rmux_s;
    logic        unused_s;

    assign req_s    = i_wb_cyc & i_wb_stb;
    assign wr_s     = req_s & i_wb_we;
    assign rd_s     = req_s & ~i_wb_we;
    assign addr_s   = i_wb_addr[4:2];
    assign w1c_s    = wr_s & (addr_s == A_STATUS) & i_wb_sel[0] & i_wb_data[0];
    assign tick_s   = ctrl_q[0] & (pcnt_q == prescale_q);
    assign match_s  = tick_s & (count_q == compare_q);
    assign unused_s = ^{i_wb_addr[31:5], i_wb_addr[1:0]};

    assign o_wb_stall = 1'b0;
    assign o_wb_ack   = ack_q;
    assign o_wb_data  = rdata_q;
    assign o_irq      = irq_q;

    // Read data mux over the current register contents.
    always_comb begin
        rmux_s = 32'd0;
        case (addr_s)
            A_CTRL:     rmux_s = {29'd0, ctrl_q};
            A_PRESCALE: rmux_s = {16'd0, prescale_q};
            A_COMPARE:  rmux_s = compare_q;
            A_COUNT:    rmux_s = count_q;
            A_STATUS:   rmux_s = {31'd0, pend_q};
            default:    rmux_s = 32'd0;
        endcase
    end

    // Next state: timer update first, then bus writes override it.
    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        compare_d  = compare_q;
        count_d    = count_q;

        if (tick_s) begin
            if (match_s) begin
                if (ctrl_q[1]) begin
                    count_d = 32'd0;
                end else begin
                    ctrl_d[0] = 1'b0;
                end
            end else begin
                count_d = count_q + 32'd1;
            end
        end else begin
            count_d = count_q;
        end

        case (addr_s)
            A_CTRL:     old_s = {29'd0, ctrl_d};
            A_PRESCALE: old_s = {16'd0, prescale_q};
            A_COMPARE:  old_s = compare_q;
            A_COUNT:    old_s = count_d;
            default:    old_s = 32'd0;
        endcase
        merged_s = merge_lanes(old_s, i_wb_data, i_wb_sel);

        if (wr_s) begin
            case (addr_s)
                A_CTRL:     ctrl_d     = merged_s[2:0];
                A_PRESCALE: prescale_d = merged_s[15:0];
                A_COMPARE:  compare_d  = merged_s;
                A_COUNT:    count_d    = merged_s;
                default:    ctrl_d     = ctrl_d;
            endcase
        end else begin
            ctrl_d = ctrl_d;
        end

        // Prescaler only advances while enabled before and after this edge,
        // so enabling always starts from zero.
        pcnt_d  = (ctrl_q[0] && ctrl_d[0] && !tick_s) ? pcnt_q + 16'd1 : 16'd0;
        pend_d  = match_s | (pend_q & ~w1c_s);
        irq_d   = pend_d & ctrl_d[2];
        ack_d   = req_s;
        rdata_d = rd_s ? rmux_s : 32'd0;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge i_Clk or negedge i_Rstn) begin
        if (!i_Rstn) begin
            ctrl_q     <= 3'd0;
            prescale_q <= 16'd0;
            compare_q  <= 32'hFFFF_FFFF;
            count_q    <= 32'd0;
            pcnt_q     <= 16'd0;
            pend_q     <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= 32'd0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            compare_q  <= compare_d;
            count_q    <= count_d;
            pcnt_q     <= pcnt_d;
            pend_q     <= pend_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end

endmodule

// File: tb/tb_wb_timer_irq.sv
// Directed self-checking bench for wb_timer_irq; inputs change on negedges,
// outputs are sampled on negedges, away from the active rising edge.
module tb_wb_timer_irq;

    logic        i_Clk = 1'b0;
    logic        i_Rstn;
    logic        i_wb_cyc, i_wb_stb, i_wb_we;
    logic [31:0] i_wb_addr, i_wb_data;
    logic [3:0]  i_wb_sel;
    logic        o_wb_stall, o_wb_ack, o_irq;
    logic [31:0] o_wb_data;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam logic [31:0] CTRL = 32'h00, PRESC = 32'h04, CMP = 32'h08,
                            CNT = 32'h0C, STAT = 32'h10, UNUSED = 32'h14;

    wb_timer_irq dut (
        .i_Clk      (i_Clk),
        .i_Rstn     (i_Rstn),
        .i_wb_cyc   (i_wb_cyc),
        .i_wb_stb   (i_wb_stb),
        .i_wb_we    (i_wb_we),
        .i_wb_addr  (i_wb_addr),
        .i_wb_data  (i_wb_data),
        .i_wb_sel   (i_wb_sel),
        .o_wb_stall (o_wb_stall),
        .o_wb_ack   (o_wb_ack),
        .o_wb_data  (o_wb_data),
        .o_irq      (o_irq)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
        i_wb_addr = 32'd0; i_wb_data = 32'd0; i_wb_sel = 4'd0;
    endtask

    // One single-cycle request; ack must be low before and high one cycle after.
    task automatic wb(input logic we, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] sel, output logic [31:0] rd);
        @(negedge i_Clk);
        check("ack_before_req", {31'd0, o_wb_ack}, 32'd0);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we;
        i_wb_addr = addr; i_wb_data = data; i_wb_sel = sel;
        @(negedge i_Clk);
        check("ack_after_req", {31'd0, o_wb_ack}, 32'd1);
        rd = o_wb_data;
        bus_idle();
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
        logic [31:0] d;
        wb(1'b1, addr, data, sel, d);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        wb(1'b0, addr, 32'd0, 4'hF, d);
        check(tag, d, exp);
    endtask

    initial begin
        i_Rstn = 1'b0;
        bus_idle();
        #1;
        check("rst_irq", {31'd0, o_irq}, 32'd0);
        check("rst_ack", {31'd0, o_wb_ack}, 32'd0);
        check("stall", {31'd0, o_wb_stall}, 32'd0);
        repeat (2) @(negedge i_Clk);
        i_Rstn = 1'b1;

        // Reset values and unused address space
        rd_chk("rst_ctrl", CTRL, 32'd0);
        rd_chk("rst_presc", PRESC, 32'd0);
        rd_chk("rst_cmp", CMP, 32'hFFFF_FFFF);
        rd_chk("rst_cnt", CNT, 32'd0);
        rd_chk("rst_stat", STAT, 32'd0);
        wr(UNUSED, 32'hDEAD_BEEF, 4'hF);
        rd_chk("unused_rd", UNUSED, 32'd0);

        // Byte lanes, zero-sel write, upper address bits ignored
        wr(PRESC, 32'h0000_1234, 4'b0001);
        rd_chk("presc_lane0", PRESC, 32'h0000_0034);
        wr(CMP, 32'h0000_0000, 4'b0000);
        rd_chk("cmp_sel0", CMP, 32'hFFFF_FFFF);
        wr(32'h0000_0108, 32'hAABB_CCDD, 4'b1010);
        rd_chk("cmp_lanes", CMP, 32'hAAFF_CCFF);

        // Auto-reload: PRESCALE=3, COMPARE=2, CTRL=EN|AUTO|IE
        wr(PRESC, 32'd3, 4'hF);
        wr(CMP, 32'd2, 4'hF);
        wr(CTRL, 32'h7, 4'hF);
        rd_chk("ar_cnt_k2", CNT, 32'd0);
        rd_chk("ar_cnt_k4", CNT, 32'd0);
        rd_chk("ar_cnt_k6", CNT, 32'd1);
        rd_chk("ar_cnt_k8", CNT, 32'd1);
        rd_chk("ar_cnt_k10", CNT, 32'd2);
        @(negedge i_Clk);
        check("ar_irq_k11", {31'd0, o_irq}, 32'd0);
        @(negedge i_Clk);
        check("ar_irq_k12", {31'd0, o_irq}, 32'd1);
        rd_chk("ar_cnt_reload", CNT, 32'd0);
        rd_chk("ar_pend", STAT, 32'd1);
        rd_chk("ar_en_kept", CTRL, 32'd7);
        wr(CTRL, 32'h4, 4'hF);
        wr(STAT, 32'h1, 4'b0001);
        rd_chk("ar_pend_clr", STAT, 32'd0);
        check("ar_irq_clr", {31'd0, o_irq}, 32'd0);

        // One-shot: PRESCALE=0, COMPARE=5, CTRL=EN|IE
        wr(CNT, 32'd0, 4'hF);
        wr(PRESC, 32'd0, 4'hF);
        wr(CMP, 32'd5, 4'hF);
        wr(CTRL, 32'h5, 4'hF);
        repeat (8) @(negedge i_Clk);
        rd_chk("os_ctrl", CTRL, 32'h4);
        rd_chk("os_cnt", CNT, 32'd5);
        rd_chk("os_pend", STAT, 32'd1);
        check("os_irq", {31'd0, o_irq}, 32'd1);
        repeat (4) @(negedge i_Clk);
        rd_chk("os_cnt_hold", CNT, 32'd5);
        wr(STAT, 32'h1, 4'b0001);
        check("os_irq_clr", {31'd0, o_irq}, 32'd0);

        // Collision: W1C lands in the match cycle (cycle 4 after enable)
        wr(CNT, 32'd0, 4'hF);
        wr(CMP, 32'd3, 4'hF);
        wr(CTRL, 32'h5, 4'hF);
        repeat (2) @(negedge i_Clk);
        wr(STAT, 32'h1, 4'b0001);
        check("col_irq", {31'd0, o_irq}, 32'd1);
        rd_chk("col_pend", STAT, 32'd1);
        check("col_irq_pre", {31'd0, o_irq}, 32'd1);
        wr(STAT, 32'h1, 4'b0001);
        check("col_irq_drop", {31'd0, o_irq}, 32'd0);

        // Wrap and bus-write priority over a TICK
        wr(CMP, 32'h10, 4'hF);
        wr(PRESC, 32'd0, 4'hF);
        wr(CNT, 32'hFFFF_FFFF, 4'hF);
        wr(CTRL, 32'h3, 4'hF);
        rd_chk("wrap_cnt", CNT, 32'd0);
        @(negedge i_Clk);
        check("b2b_idle", {31'd0, o_wb_ack}, 32'd0);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1;
        i_wb_addr = CNT; i_wb_data = 32'h55; i_wb_sel = 4'hF;
        @(negedge i_Clk);
        check("b2b_ack1", {31'd0, o_wb_ack}, 32'd1);
        i_wb_we = 1'b0; i_wb_data = 32'd0;
        @(negedge i_Clk);
        check("b2b_ack2", {31'd0, o_wb_ack}, 32'd1);
        check("prio_cnt", o_wb_data, 32'h55);
        bus_idle();
        @(negedge i_Clk);
        check("b2b_ack_end", {31'd0, o_wb_ack}, 32'd0);
        check("b2b_data_end", o_wb_data, 32'd0);
        wr(CTRL, 32'h0, 4'hF);

        // Async reset between edges with irq high and an ack pending
        wr(CNT, 32'd0, 4'hF);
        wr(CMP, 32'd2, 4'hF);
        wr(CTRL, 32'h5, 4'hF);
        repeat (4) @(negedge i_Clk);
        check("ar_pre_irq", {31'd0, o_irq}, 32'd1);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0;
        i_wb_addr = CTRL; i_wb_sel = 4'hF;
        @(posedge i_Clk);
        #2;
        check("ar_pre_ack", {31'd0, o_wb_ack}, 32'd1);
        i_Rstn = 1'b0;
        #1;
        check("ar_irq", {31'd0, o_irq}, 32'd0);
        check("ar_ack", {31'd0, o_wb_ack}, 32'd0);
        check("ar_data", o_wb_data, 32'd0);
        check("ar_ctrl", {29'd0, dut.ctrl_q}, 32'd0);
        check("ar_count", dut.count_q, 32'd0);
        @(negedge i_Clk);
        bus_idle();
        @(negedge i_Clk);
        i_Rstn = 1'b1;
        rd_chk("post_rst_ctrl", CTRL, 32'd0);
        rd_chk("post_rst_cmp", CMP, 32'hFFFF_FFFF);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
